// File: rtl/system_0_sysid_pkg.sv
// system_0_sysid_pkg: checker states and sysid bus constants
package system_0_sysid_pkg;
  localparam int SYSID_DATA_W = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_DONE
  } sysid_state_e;
endpackage

// File: rtl/system_0_sysid_timeout_ctr.sv
// system_0_sysid_timeout_ctr: per-transaction cycle counter flagging the last allowed cycle
module system_0_sysid_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge clock) begin
    cnt <= (reset || clear) ? '0 : enable ? cnt + 1'b1 : cnt;
  end
  assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/system_0_sysid_checker.sv
// system_0_sysid_checker: reads sysid ID/timestamp and checks them; define SYSID_CHECK_TS_EN to also require the timestamp match
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS = 32'h63A3_8F6C,
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic                    avm_readdatavalid,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    timeout_err,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  sysid_state_e state, state_n;
  logic auto_pend, expired, in_rd, in_wait, accept, got, to_hit, enter, finish, to_n, ok_n;
  logic [SYSID_DATA_W-1:0] id_n, ts_n;
  assign in_rd = state == ST_RD_ID || state == ST_RD_TS;
  assign in_wait = state == ST_WAIT_ID || state == ST_WAIT_TS;
  assign accept = in_rd && !avm_waitrequest;
  assign got = in_wait && avm_readdatavalid;
  assign to_hit = expired && (in_rd || (in_wait && !avm_readdatavalid));
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    state_n = (start || auto_pend) ? ST_RD_ID : ST_IDLE;
      ST_RD_ID:   state_n = to_hit ? ST_DONE : accept ? ST_WAIT_ID : ST_RD_ID;
      ST_WAIT_ID: state_n = got ? ST_RD_TS : to_hit ? ST_DONE : ST_WAIT_ID;
      ST_RD_TS:   state_n = to_hit ? ST_DONE : accept ? ST_WAIT_TS : ST_RD_TS;
      ST_WAIT_TS: state_n = (got || to_hit) ? ST_DONE : ST_WAIT_TS;
      default:    state_n = ST_IDLE;
    endcase
  end
  assign enter = state == ST_IDLE && state_n == ST_RD_ID;
  assign finish = state != ST_DONE && state_n == ST_DONE;
  assign id_n = enter ? '0 : (got && state == ST_WAIT_ID) ? avm_readdata : id_value;
  assign ts_n = enter ? '0 : (got && state == ST_WAIT_TS) ? avm_readdata : ts_value;
  assign to_n = enter ? 1'b0 : timeout_err || to_hit;
  assign ok_n = enter ? 1'b0
              : finish ? (id_n == EXPECTED_ID && (!TS_EN || ts_n == EXPECTED_TS) && !to_n)
              : id_ok;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      auto_pend   <= AUTO_START;
      id_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_n;
      auto_pend   <= 1'b0;
      id_ok       <= ok_n;
      timeout_err <= to_n;
      id_value    <= id_n;
      ts_value    <= ts_n;
    end
  end
  system_0_sysid_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_n != state && (state_n == ST_RD_ID || state_n == ST_RD_TS)),
    .enable  (busy),
    .expired (expired)
  );
  assign avm_read = in_rd;
  assign avm_address = (state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy = in_rd || in_wait;
  assign done = state == ST_DONE;
endmodule
